// File: rtl/aes_wb_slice.sv
// aes_wb_slice: registered Wishbone classic slave slice in front of the aes_example core.
// Requests inside the AES address window are registered toward the core. Requests
// outside the window are acknowledged locally with zero data. The core's ack and
// read data are captured and returned to the host as a one-cycle ack.
// Optional feature macro: AES_WB_TIMEOUT_EN. When defined, a core that never acks is
// abandoned after TIMEOUT_CYCLES request cycles. The host then gets ERR_DATA and a
// timeout_o pulse.
module aes_wb_slice #(
  parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        wbsAck_q;
  logic [31:0] wbsDat_q;
  logic        sCyc_q;
  logic        sStb_q;
  logic        sWe_q;
  logic [3:0]  sSel_q;
  logic [31:0] sAdr_q;
  logic [31:0] sDat_q;

  logic hostReq;
  logic addrHit;
  logic timeoutFire;

  assign hostReq = wbs_cyc_i & wbs_stb_i;
  assign addrHit = ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);

  // A timeout window shorter than two cycles cannot be represented by the counter.
  if (TIMEOUT_CYCLES < 2) begin : gTimeoutCheck
    $error("aes_wb_slice: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef AES_WB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmoCnt_q;
  logic [CNT_W-1:0] tmoCnt_d;
  logic             timeout_q;

  // The counter sits at zero outside REQ, so it is already cleared when REQ is
  // entered. It counts REQ cycles without a core ack, and the last count fires the
  // forced ack.
  always_comb begin
    tmoCnt_d    = '0;
    timeoutFire = 1'b0;
    if ((state_q == REQ) && !s_ack_i) begin
      if (tmoCnt_q == CNT_LAST) begin
        tmoCnt_d    = tmoCnt_q;
        timeoutFire = wbs_cyc_i;
      end else begin
        tmoCnt_d = tmoCnt_q + 1'b1;
      end
    end
  end

  // Timeout counter register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmoCnt_q <= '0;
    end else begin
      tmoCnt_q <= tmoCnt_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeoutFire = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Transaction FSM. Every output is driven from a register in this block. A host
  // abort outranks a core ack, and a core ack outranks a timeout in the same cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      wbsAck_q <= 1'b0;
      wbsDat_q <= '0;
      sCyc_q   <= 1'b0;
      sStb_q   <= 1'b0;
      sWe_q    <= 1'b0;
      sSel_q   <= '0;
      sAdr_q   <= '0;
      sDat_q   <= '0;
`ifdef AES_WB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      wbsAck_q <= 1'b0;
`ifdef AES_WB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (hostReq) begin
            if (addrHit) begin
              sCyc_q  <= 1'b1;
              sStb_q  <= 1'b1;
              sWe_q   <= wbs_we_i;
              sSel_q  <= wbs_sel_i;
              sAdr_q  <= wbs_adr_i;
              sDat_q  <= wbs_dat_i;
              state_q <= REQ;
            end else begin
              wbsDat_q <= '0;
              wbsAck_q <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        REQ: begin
          if (!wbs_cyc_i) begin
            sCyc_q  <= 1'b0;
            sStb_q  <= 1'b0;
            state_q <= IDLE;
          end else if (s_ack_i) begin
            wbsDat_q <= sWe_q ? 32'h0 : s_dat_i;
            sCyc_q   <= 1'b0;
            sStb_q   <= 1'b0;
            wbsAck_q <= 1'b1;
            state_q  <= RESP;
          end else if (timeoutFire) begin
            wbsDat_q <= ERR_DATA;
            sCyc_q   <= 1'b0;
            sStb_q   <= 1'b0;
            wbsAck_q <= 1'b1;
`ifdef AES_WB_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
            state_q  <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o = wbsAck_q;
  assign wbs_dat_o = wbsDat_q;
  assign s_cyc_o   = sCyc_q;
  assign s_stb_o   = sStb_q;
  assign s_we_o    = sWe_q;
  assign s_sel_o   = sSel_q;
  assign s_adr_o   = sAdr_q;
  assign s_dat_o   = sDat_q;

endmodule

// File: tb/tb_aes_wb_slice.sv
// tb_aes_wb_slice: self-checking bench for aes_wb_slice.
// The bench instantiates the slice with TIMEOUT_CYCLES=8. The timeout scenario takes
// the branch that matches AES_WB_TIMEOUT_EN.
module tb_aes_wb_slice;

  localparam int unsigned TMO = 8;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic        timeout_o;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } snap_t;

  int          nCompared;
  int          nMismatched;
  logic [31:0] expQ[$];

  aes_wb_slice #(
    .ADDR_BASE      (32'h3000_0000),
    .ADDR_MASK      (32'hFFFF_F000),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_ack_i   (s_ack_i),
    .s_dat_i   (s_dat_i),
    .timeout_o (timeout_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // Runs one host transaction with a scripted core. Cycle c is the period that
  // follows the c-th rising edge after the request was sampled. The core raises
  // s_ack_i during cycle ackAt (0 = never). The host drops cyc in cycle abortAt
  // (0 = never). The host drops stb after the ack, or one cycle later when holdStb is set.
  task automatic runTxn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int ackAt, input logic [31:0] coreDat,
                        input int abortAt, input bit holdStb, input int maxCyc,
                        output int ackLat, output int ackCount, output int stbLast,
                        output int stbCount, output logic [31:0] ackData,
                        output logic [31:0] datAfter, output int toCount, output snap_t snap);
    ackLat = 0; ackCount = 0; stbLast = 0; stbCount = 0; toCount = 0;
    ackData = 'x; datAfter = 'x; snap = 'x;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    @(posedge wb_clk_i);
    for (int c = 1; c <= maxCyc; c++) begin
      @(negedge wb_clk_i);
      if (s_stb_o) begin stbLast = c; stbCount++; end
      if (c == 1) snap = '{s_cyc_o, s_we_o, s_sel_o, s_adr_o, s_dat_o};
      if (timeout_o) toCount++;
      if (ackLat != 0 && c == ackLat + 1) datAfter = wbs_dat_o;
      if (wbs_ack_o) begin
        ackCount++;
        if (ackLat == 0) begin ackLat = c; ackData = wbs_dat_o; end
      end
      if (ackLat != 0 && (!holdStb || c == ackLat + 1)) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
      if (c == abortAt) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      s_ack_i = (c == ackAt);
      s_dat_i = (c == ackAt) ? coreDat : 32'h0;
      if (ackLat != 0 && c >= ackLat + 4) break;
    end
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  // Shared outputs for the transaction runner.
  int          lat, nAck, stbLast, stbCnt, toCnt;
  logic [31:0] aDat, aAfter, exp;
  snap_t       snap;

  task automatic test_reset;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
    repeat (3) @(negedge wb_clk_i);
    nCompared++;
    if ({wbs_ack_o, s_cyc_o, s_stb_o, s_we_o, timeout_o} !== 5'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000", {wbs_ack_o, s_cyc_o, s_stb_o, s_we_o, timeout_o});
    end
    nCompared++;
    if ({wbs_dat_o, s_adr_o, s_dat_o, s_sel_o} !== 100'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_data: got dat=%h adr=%h sdat=%h sel=%h want all 0",
               wbs_dat_o, s_adr_o, s_dat_o, s_sel_o);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic test_hit_read;
    expQ.push_back(32'h1234_5678);
    runTxn(32'h3000_0004, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, 0, 1'b0, 20,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (lat !== 4) begin nMismatched++; $display("[TB] FAIL read_latency: got %0d want 4", lat); end
    nCompared++;
    if (aDat !== exp) begin nMismatched++; $display("[TB] FAIL read_data: got %h want %h", aDat, exp); end
    nCompared++;
    if (nAck !== 1) begin nMismatched++; $display("[TB] FAIL read_ack_width: got %0d want 1", nAck); end
    nCompared++;
    if (stbCnt !== 3 || stbLast !== 3) begin
      nMismatched++; $display("[TB] FAIL read_stb: got cnt=%0d last=%0d want 3/3", stbCnt, stbLast);
    end
    nCompared++;
    if (aAfter !== 32'h1234_5678) begin
      nMismatched++; $display("[TB] FAIL read_hold: got %h want 12345678", aAfter);
    end
  endtask

  task automatic test_miss;
    expQ.push_back(32'h0);
    runTxn(32'h3000_1000, 1'b0, 32'h0, 4'hF, 1, 32'h7777_7777, 0, 1'b0, 20,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (lat !== 1) begin nMismatched++; $display("[TB] FAIL miss_latency: got %0d want 1", lat); end
    nCompared++;
    if (aDat !== exp) begin nMismatched++; $display("[TB] FAIL miss_data: got %h want %h", aDat, exp); end
    nCompared++;
    if (stbCnt !== 0) begin nMismatched++; $display("[TB] FAIL miss_stb: got %0d want 0", stbCnt); end
  endtask

  task automatic test_hit_write;
    expQ.push_back(32'h0);
    runTxn(32'h3000_0000, 1'b1, 32'hA5A5_A5A5, 4'hF, 2, 32'hFFFF_0000, 0, 1'b0, 20,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (snap !== snap_t'{1'b1, 1'b1, 4'hF, 32'h3000_0000, 32'hA5A5_A5A5}) begin
      nMismatched++; $display("[TB] FAIL write_req: got %h want %h", snap,
                              snap_t'{1'b1, 1'b1, 4'hF, 32'h3000_0000, 32'hA5A5_A5A5});
    end
    nCompared++;
    if (lat !== 3) begin nMismatched++; $display("[TB] FAIL write_latency: got %0d want 3", lat); end
    nCompared++;
    if (aDat !== exp) begin nMismatched++; $display("[TB] FAIL write_data: got %h want %h", aDat, exp); end
  endtask

  task automatic test_back_to_back;
    // Fastest core; host keeps stb up one extra cycle, which must not re-issue.
    expQ.push_back(32'h0BAD_CAFE);
    runTxn(32'h3000_0ABC, 1'b0, 32'h0, 4'h3, 1, 32'h0BAD_CAFE, 0, 1'b1, 20,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (lat !== 2) begin nMismatched++; $display("[TB] FAIL min_latency: got %0d want 2", lat); end
    nCompared++;
    if (aDat !== exp) begin nMismatched++; $display("[TB] FAIL b2b_data0: got %h want %h", aDat, exp); end
    nCompared++;
    if (stbCnt !== 1 || nAck !== 1) begin
      nMismatched++; $display("[TB] FAIL no_reissue: got stb=%0d ack=%0d want 1/1", stbCnt, nAck);
    end
    nCompared++;
    if (snap.sel !== 4'h3 || snap.adr !== 32'h3000_0ABC) begin
      nMismatched++; $display("[TB] FAIL b2b_req: got sel=%h adr=%h want 3/30000abc", snap.sel, snap.adr);
    end
    expQ.push_back(32'h5555_AAAA);
    runTxn(32'h3000_0FFC, 1'b0, 32'h0, 4'hF, 2, 32'h5555_AAAA, 0, 1'b0, 20,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (aDat !== exp || lat !== 3) begin
      nMismatched++; $display("[TB] FAIL b2b_data1: got %h lat=%0d want %h lat=3", aDat, lat, exp);
    end
  endtask

  task automatic test_stray_ack;
    int seen;
    seen = 0;
    @(negedge wb_clk_i);
    s_ack_i = 1'b1; s_dat_i = 32'h1111_2222;
    @(negedge wb_clk_i);
    s_ack_i = 1'b0; s_dat_i = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (wbs_ack_o || s_stb_o) seen++;
      @(negedge wb_clk_i);
    end
    nCompared++;
    if (seen !== 0) begin nMismatched++; $display("[TB] FAIL stray_ack: got %0d activity cycles want 0", seen); end
  endtask

  task automatic test_abort;
    runTxn(32'h3000_0020, 1'b0, 32'h0, 4'hF, 3, 32'h9999_9999, 2, 1'b0, 10,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    nCompared++;
    if (nAck !== 0 || stbLast !== 2) begin
      nMismatched++; $display("[TB] FAIL abort: got ack=%0d stbLast=%0d want 0/2", nAck, stbLast);
    end
    runTxn(32'h3000_0024, 1'b0, 32'h0, 4'hF, 2, 32'h8888_8888, 2, 1'b0, 10,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    nCompared++;
    if (nAck !== 0 || stbLast !== 2) begin
      nMismatched++; $display("[TB] FAIL abort_vs_ack: got ack=%0d stbLast=%0d want 0/2", nAck, stbLast);
    end
  endtask

  task automatic test_timeout;
    // A core ack on the final counting cycle must still be a normal ack.
    expQ.push_back(32'h4242_4242);
    runTxn(32'h3000_0030, 1'b0, 32'h0, 4'hF, TMO, 32'h4242_4242, 0, 1'b0, 30,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (aDat !== exp || lat !== TMO + 1 || toCnt !== 0) begin
      nMismatched++; $display("[TB] FAIL late_ack: got %h lat=%0d to=%0d want %h lat=%0d to=0",
                              aDat, lat, toCnt, exp, TMO + 1);
    end
`ifdef AES_WB_TIMEOUT_EN
    expQ.push_back(32'hDEAD_BEEF);
    runTxn(32'h3000_0034, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 1'b0, 40,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (lat !== TMO + 1 || nAck !== 1) begin
      nMismatched++; $display("[TB] FAIL timeout_latency: got %0d acks=%0d want %0d/1", lat, nAck, TMO + 1);
    end
    nCompared++;
    if (aDat !== exp) begin nMismatched++; $display("[TB] FAIL timeout_data: got %h want %h", aDat, exp); end
    nCompared++;
    if (toCnt !== 1 || stbLast !== TMO) begin
      nMismatched++; $display("[TB] FAIL timeout_pulse: got pulses=%0d stbLast=%0d want 1/%0d",
                              toCnt, stbLast, TMO);
    end
`else
    runTxn(32'h3000_0034, 1'b0, 32'h0, 4'hF, 0, 32'h0, 0, 1'b0, 1000,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    nCompared++;
    if (nAck !== 0 || toCnt !== 0 || stbLast !== 1000) begin
      nMismatched++; $display("[TB] FAIL no_timeout: got ack=%0d to=%0d stbLast=%0d want 0/0/1000",
                              nAck, toCnt, stbLast);
    end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'hC; wbs_adr_i = 32'h3000_0040; wbs_dat_i = 32'h1357_9BDF;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    nCompared++;
    if (s_stb_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_req: got s_stb_o=%b want 1", s_stb_o); end
    #2 wb_rst_i = 1'b1;
    #1;
    nCompared++;
    if ({wbs_ack_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o} !== 72'h0) begin
      nMismatched++; $display("[TB] FAIL mid_reset: got ack=%b cyc=%b stb=%b adr=%h dat=%h want all 0",
                              wbs_ack_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    expQ.push_back(32'hCAFE_F00D);
    runTxn(32'h3000_0010, 1'b0, 32'h0, 4'hF, 2, 32'hCAFE_F00D, 0, 1'b0, 20,
           lat, nAck, stbLast, stbCnt, aDat, aAfter, toCnt, snap);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
    nCompared++;
    if (aDat !== exp || lat !== 3) begin
      nMismatched++; $display("[TB] FAIL post_reset_read: got %h lat=%0d want %h lat=3", aDat, lat, exp);
    end
    nCompared++;
    if (expQ.size() !== 0) begin
      nMismatched++; $display("[TB] FAIL scoreboard_drain: got %0d left want 0", expQ.size());
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_hit_read();
    test_miss();
    test_hit_write();
    test_back_to_back();
    test_stray_ack();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
